matrix_alu_seq: RTL

//  Sequential, parametrised successor of the combinational 5x5 matrix ALU.

---
 rtl/matrix_alu_pkg.sv | 34 +++
 rtl/matrix_mac_unit.sv | 36 +++
 rtl/matrix_alu_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/matrix_alu_pkg.sv
// Shared opcodes, FSM state type and indexing/range helpers for the sequential matrix ALU.
package matrix_alu_pkg;

    localparam int N_MAX_DEFAULT  = 5;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_OPP = 3'b100;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_SCL = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    // Bit offset of element (r,c) in a row-major flat matrix bus.
    function automatic int unsigned elem_idx(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n_max  = N_MAX_DEFAULT,
                                             input int unsigned data_w = DATA_W_DEFAULT);
        return (r * n_max + c) * data_w;
    endfunction

    function automatic logic out_of_range(input longint v, input int unsigned w);
        longint lim;
        lim = longint'(1) <<< (w - 1);
        return (v >= lim) || (v < -lim);
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Signed multiply-accumulate step; `first` starts a fresh sum, `en` commits it.
module matrix_mac_unit
    import matrix_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = 2 * DATA_W_DEFAULT + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    prod_w;
    logic signed [2*DATA_W-1:0] prod;

    // acc_next is the completed sum on the step that finishes an element.
    always_comb begin
        prod     = a * b;
        prod_w   = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
        acc_next = (first ? '0 : acc) + prod_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential NxN signed matrix ALU: one element (or one MAC step) per clock,
// start/busy/done handshake, saturation detection with wrapped results.
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int N_MAX  = N_MAX_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [2:0]                       opcode,
    input  logic [$clog2(N_MAX+1)-1:0]       n,
    input  logic [DATA_W-1:0]                f,
    input  logic [N_MAX*N_MAX*DATA_W-1:0]    A_flat,
    input  logic [N_MAX*N_MAX*DATA_W-1:0]    B_flat,
    output logic [N_MAX*N_MAX*DATA_W-1:0]    C_flat,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow_flag,
    output logic                             error
);

    localparam int NW     = $clog2(N_MAX + 1);
    localparam int FLAT_W = N_MAX * N_MAX * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_MAX);

    state_t             state;
    logic [FLAT_W-1:0]  a_q, b_q;
    logic [DATA_W-1:0]  f_q;
    logic [2:0]         op_q;
    logic [NW-1:0]      n_q, r, c, k, n_last;

    int unsigned              idx_rc, idx_cr, idx_rk, idx_kc;
    logic signed [DATA_W-1:0] a_e, b_e, a_t, mac_a, mac_b;
    logic signed [ACC_W-1:0]  a_w, b_w, mac_next, res_full;
    logic                     mac_first, last_k, last_c, last_r, legal;

    always_comb begin
        idx_rc    = elem_idx(int'(r), int'(c), N_MAX, DATA_W);
        idx_cr    = elem_idx(int'(c), int'(r), N_MAX, DATA_W);
        idx_rk    = elem_idx(int'(r), int'(k), N_MAX, DATA_W);
        idx_kc    = elem_idx(int'(k), int'(c), N_MAX, DATA_W);
        a_e       = a_q[idx_rc +: DATA_W];
        b_e       = b_q[idx_rc +: DATA_W];
        a_t       = a_q[idx_cr +: DATA_W];
        a_w       = {{(ACC_W - DATA_W){a_e[DATA_W-1]}}, a_e};
        b_w       = {{(ACC_W - DATA_W){b_e[DATA_W-1]}}, b_e};
        // The MAC serves mul (A row x B column over k) and scalar (A x f, one step).
        mac_a     = (op_q == OP_MUL) ? a_q[idx_rk +: DATA_W] : a_e;
        mac_b     = (op_q == OP_MUL) ? b_q[idx_kc +: DATA_W] : f_q;
        mac_first = (op_q != OP_MUL) || (k == '0);
        n_last    = n_q - NW'(1);
        last_k    = (op_q != OP_MUL) || (k == n_last);
        last_c    = (c == n_last);
        last_r    = (r == n_last);
        legal     = (opcode != 3'b000) && (opcode != 3'b111) &&
                    (n != '0) && (int'(n) <= N_MAX);
        case (op_q)
            OP_ADD:  res_full = a_w + b_w;
            OP_SUB:  res_full = a_w - b_w;
            OP_OPP:  res_full = -a_w;
            OP_TRN:  res_full = {{(ACC_W - DATA_W){a_t[DATA_W-1]}}, a_t};
            OP_MUL,
            OP_SCL:  res_full = mac_next;
            default: res_full = '0;
        endcase
    end

    matrix_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ST_COMPUTE),
        .first    (mac_first),
        .a        (mac_a),
        .b        (mac_b),
        .acc_next (mac_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            C_flat        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow_flag <= 1'b0;
            error         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            f_q           <= '0;
            op_q          <= '0;
            n_q           <= '0;
            r             <= '0;
            c             <= '0;
            k             <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q           <= A_flat;
                        b_q           <= B_flat;
                        f_q           <= f;
                        op_q          <= opcode;
                        n_q           <= n;
                        r             <= '0;
                        c             <= '0;
                        k             <= '0;
                        C_flat        <= '0;
                        overflow_flag <= 1'b0;
                        if (legal) begin
                            error <= 1'b0;
                            busy  <= 1'b1;
                            state <= ST_COMPUTE;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (last_k) begin
                        C_flat[idx_rc +: DATA_W] <= res_full[DATA_W-1:0];
                        if (out_of_range(longint'(res_full), DATA_W)) begin
                            overflow_flag <= 1'b1;
                        end
                        k <= '0;
                        if (last_c) begin
                            c <= '0;
                            if (last_r) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                r <= r + NW'(1);
                            end
                        end else begin
                            c <= c + NW'(1);
                        end
                    end else begin
                        k <= k + NW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
